// File: rtl/config_loader_pkg.sv
// Shared types for the game config loader: record layout, byte offsets,
// field selectors, error causes and loader states.
package config_loader_pkg;

  localparam int CONFIG_BYTES = 44;
  localparam logic [7:0] CONFIG_MAGIC0  = 8'h47;
  localparam logic [7:0] CONFIG_MAGIC1  = 8'h57;
  localparam logic [7:0] CONFIG_VERSION = 8'h01;

  localparam int OFF_VERSION   = 2;
  localparam int OFF_MPU       = 3;
  localparam int OFF_SCREEN    = 4;
  localparam int OFF_WIDTH     = 5;
  localparam int OFF_HEIGHT    = 7;
  localparam int OFF_INPUT_S   = 9;
  localparam int OFF_INPUT_B   = 41;
  localparam int OFF_INPUT_BA  = 42;
  localparam int OFF_INPUT_ACL = 43;

  typedef enum logic [3:0] {
    FLD_NONE,
    FLD_MPU,
    FLD_SCREEN,
    FLD_WIDTH,
    FLD_HEIGHT,
    FLD_INPUT_S,
    FLD_INPUT_B,
    FLD_INPUT_BA,
    FLD_INPUT_ACL
  } field_sel_t;

  typedef enum logic [1:0] {
    CFG_ERR_NONE    = 2'd0,
    CFG_ERR_MAGIC   = 2'd1,
    CFG_ERR_VERSION = 2'd2,
    CFG_ERR_FORMAT  = 2'd3
  } config_error_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_BODY,
    ST_COMMIT,
    ST_FAIL
  } load_state_t;

  typedef struct packed {
    logic [7:0]       mpu;
    logic [7:0]       screen_config;
    logic [11:0]      screen_width;
    logic [11:0]      screen_height;
    logic [7:0][31:0] input_s_config;
    logic [7:0]       input_b_config;
    logic [7:0]       input_ba_config;
    logic [7:0]       input_acl_config;
  } system_config_t;

endpackage

// File: rtl/config_loader_field_decoder.sv
// Maps a stream byte offset to the config field it lands in, the slot for
// the eight input words, and whether it is the most significant byte.
module config_field_decoder
  import config_loader_pkg::*;
(
  input  logic [5:0]  offset_i,
  output field_sel_t  field_o,
  output logic [2:0]  slot_o,
  output logic        msb_o
);

  logic [4:0] rel;

  always_comb begin
    field_o = FLD_NONE;
    slot_o  = '0;
    msb_o   = 1'b0;
    rel     = 5'(offset_i - 6'(OFF_INPUT_S));
    if (offset_i == 6'(OFF_MPU)) begin
      field_o = FLD_MPU;
    end else if (offset_i == 6'(OFF_SCREEN)) begin
      field_o = FLD_SCREEN;
    end else if (offset_i == 6'(OFF_WIDTH) || offset_i == 6'(OFF_WIDTH + 1)) begin
      field_o = FLD_WIDTH;
      msb_o   = (offset_i == 6'(OFF_WIDTH));
    end else if (offset_i == 6'(OFF_HEIGHT) || offset_i == 6'(OFF_HEIGHT + 1)) begin
      field_o = FLD_HEIGHT;
      msb_o   = (offset_i == 6'(OFF_HEIGHT));
    end else if (offset_i >= 6'(OFF_INPUT_S) && offset_i < 6'(OFF_INPUT_B)) begin
      field_o = FLD_INPUT_S;
      slot_o  = rel[4:2];
      msb_o   = (rel[1:0] == 2'b00);
    end else if (offset_i == 6'(OFF_INPUT_B)) begin
      field_o = FLD_INPUT_B;
    end else if (offset_i == 6'(OFF_INPUT_BA)) begin
      field_o = FLD_INPUT_BA;
    end else if (offset_i == 6'(OFF_INPUT_ACL)) begin
      field_o = FLD_INPUT_ACL;
    end
  end

endmodule

// File: rtl/config_loader.sv
// Parses the 44-byte big-endian config section into a shadow record and
// commits it atomically to the live config once the whole image validates.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter logic [7:0]  VERSION        = CONFIG_VERSION
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           in_valid,
  input  logic [7:0]     in_data,
  output logic           in_ready,
  output logic           busy,
  output system_config_t config_out,
  output logic           config_valid,
  output logic           error,
  output logic [1:0]     error_code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]     rst_sync_q;
  logic           rst_n;
  load_state_t    state_q, state_d;
  system_config_t shadow_q, shadow_d;
  system_config_t cfg_q, cfg_d;
  logic [5:0]     byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  config_error_t  code_q, code_d;
  config_error_t  fail_code_q, fail_code_d;
  logic           restart_q, restart_d;
  logic           xfer;
  logic           fmt_err;
  field_sel_t     fld;
  logic [2:0]     fld_slot;
  logic           fld_msb;

  // Reset asserts asynchronously but releases two clocks later, in step with clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  config_field_decoder u_decoder (
    .offset_i (byte_cnt_q),
    .field_o  (fld),
    .slot_o   (fld_slot),
    .msb_o    (fld_msb)
  );

  assign busy     = (state_q == ST_HEADER) || (state_q == ST_BODY);
  assign in_ready = busy && !start;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    // NOTE: every *_d gets its hold value first so no path through this block can infer a latch.
    state_d     = state_q;
    shadow_d    = shadow_q;
    cfg_d       = cfg_q;
    byte_cnt_d  = byte_cnt_q;
    tmo_d       = tmo_q;
    valid_d     = valid_q;
    err_d       = err_q;
    code_d      = code_q;
    fail_code_d = fail_code_q;
    restart_d   = restart_q;
    fmt_err     = 1'b0;

    case (state_q)
      ST_IDLE: ;
      ST_HEADER, ST_BODY: begin
        // A start taken in the FAIL cycle clears the reported error one cycle late.
        if (state_q == ST_HEADER && restart_q) begin
          err_d     = 1'b0;
          code_d    = CFG_ERR_NONE;
          restart_d = 1'b0;
        end
        if (xfer) begin
          tmo_d      = '0;
          byte_cnt_d = byte_cnt_q + 6'd1;
          if (state_q == ST_HEADER) begin
            if ((byte_cnt_q == 6'd0 && in_data != CONFIG_MAGIC0) ||
                (byte_cnt_q == 6'd1 && in_data != CONFIG_MAGIC1)) begin
              state_d     = ST_FAIL;
              fail_code_d = CFG_ERR_MAGIC;
            end else if (byte_cnt_q == 6'(OFF_VERSION)) begin
              if (in_data != VERSION) begin
                state_d     = ST_FAIL;
                fail_code_d = CFG_ERR_VERSION;
              end else begin
                state_d = ST_BODY;
              end
            end
          end else begin
            case (fld)
              FLD_MPU:       shadow_d.mpu           = in_data;
              FLD_SCREEN:    shadow_d.screen_config = in_data;
              FLD_WIDTH: begin
                shadow_d.screen_width = {shadow_q.screen_width[3:0], in_data};
                fmt_err = fld_msb && (in_data[7:4] != 4'h0);
              end
              FLD_HEIGHT: begin
                shadow_d.screen_height = {shadow_q.screen_height[3:0], in_data};
                fmt_err = fld_msb && (in_data[7:4] != 4'h0);
              end
              FLD_INPUT_S:
                shadow_d.input_s_config[fld_slot] =
                  {shadow_q.input_s_config[fld_slot][23:0], in_data};
              FLD_INPUT_B:   shadow_d.input_b_config   = in_data;
              FLD_INPUT_BA:  shadow_d.input_ba_config  = in_data;
              FLD_INPUT_ACL: shadow_d.input_acl_config = in_data;
              default: ;
            endcase
            if (fmt_err) begin
              state_d     = ST_FAIL;
              fail_code_d = CFG_ERR_FORMAT;
            end else if (byte_cnt_q == 6'(CONFIG_BYTES - 1)) begin
              state_d = ST_COMMIT;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d     = ST_FAIL;
          fail_code_d = CFG_ERR_FORMAT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        cfg_d   = shadow_q;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      ST_FAIL: begin
        err_d   = 1'b1;
        code_d  = fail_code_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // start overrides the next state but lets a COMMIT or FAIL finish its own updates.
    if (start) begin
      state_d    = ST_HEADER;
      shadow_d   = '0;
      byte_cnt_d = '0;
      tmo_d      = '0;
      restart_d  = (state_q == ST_FAIL);
      if (state_q != ST_FAIL) begin
        err_d  = 1'b0;
        code_d = CFG_ERR_NONE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: shadow and live records are plain flops, so they are reset like any other state.
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      cfg_q       <= '0;
      byte_cnt_q  <= '0;
      tmo_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= CFG_ERR_NONE;
      fail_code_q <= CFG_ERR_NONE;
      restart_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      cfg_q       <= cfg_d;
      byte_cnt_q  <= byte_cnt_d;
      tmo_q       <= tmo_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      code_q      <= code_d;
      fail_code_q <= fail_code_d;
      restart_q   <= restart_d;
    end
  end

  assign config_out   = cfg_q;
  assign config_valid = valid_q;
  assign error        = err_q;
  assign error_code   = code_q;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: valid loads, header/format failures,
// timeout, abort-by-start and asynchronous reset in the middle of a load.
module tb_config_loader;
  import config_loader_pkg::*;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic           in_valid = 1'b0;
  logic [7:0]     in_data = 8'h00;
  logic           in_ready;
  logic           busy;
  system_config_t config_out;
  logic           config_valid;
  logic           error;
  logic [1:0]     error_code;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] img [CONFIG_BYTES];
  system_config_t exp1, exp2, exp3;

  config_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .busy         (busy),
    .config_out   (config_out),
    .config_valid (config_valid),
    .error        (error),
    .error_code   (error_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic fill_img(input logic [7:0] mpu, input logic [7:0] scr,
                          input logic [15:0] w, input logic [15:0] h,
                          input logic [31:0] s0, input logic [7:0] b,
                          input logic [7:0] ba, input logic [7:0] acl);
    logic [31:0] s;
    img[0] = 8'h47; img[1] = 8'h57; img[2] = 8'h01;
    img[3] = mpu;   img[4] = scr;
    img[5] = w[15:8]; img[6] = w[7:0];
    img[7] = h[15:8]; img[8] = h[7:0];
    for (int k = 0; k < 8; k++) begin
      s = s0 + 32'(k);
      img[9 + 4*k]  = s[31:24];
      img[10 + 4*k] = s[23:16];
      img[11 + 4*k] = s[15:8];
      img[12 + 4*k] = s[7:0];
    end
    img[41] = b; img[42] = ba; img[43] = acl;
  endtask

  function automatic system_config_t make_cfg(input logic [7:0] mpu, input logic [7:0] scr,
                                              input logic [11:0] w, input logic [11:0] h,
                                              input logic [31:0] s0, input logic [7:0] b,
                                              input logic [7:0] ba, input logic [7:0] acl);
    system_config_t c;
    c.mpu = mpu; c.screen_config = scr;
    c.screen_width = w; c.screen_height = h;
    for (int k = 0; k < 8; k++) c.input_s_config[k] = s0 + 32'(k);
    c.input_b_config = b; c.input_ba_config = ba; c.input_acl_config = acl;
    return c;
  endfunction

  // Presents one byte for one cycle after an optional idle gap; reports whether it was taken.
  task automatic send_byte(input logic [7:0] b, input int gap, output logic took, output int at);
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    took = in_ready;
    at   = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_img(input int first, input int last, input int max_gap,
                          output int t_first, output int drops);
    logic took;
    int at, gap;
    drops = 0;
    t_first = -1;
    for (int i = first; i <= last; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      send_byte(img[i], gap, took, at);
      if (i == first) t_first = at;
      if (!took) drops++;
    end
  endtask

  task automatic wait_commit(input system_config_t exp, output int at);
    at = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (config_valid === 1'b1 && config_out === exp) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    logic took;
    int t0, t1, drops, n;

    // Reset values while reset is held.
    repeat (3) tick();
    @(negedge clk);
    check("rst_config_out", config_out, '0);
    check("rst_config_valid", config_valid, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_error_code", error_code, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    tick();
    reset_n = 1'b1;
    repeat (4) tick();

    // Bytes offered in IDLE are not consumed.
    send_byte(8'h47, 0, took, t0);
    check("idle_no_accept", took, 1'b0);

    // Valid image, back-to-back.
    fill_img(8'h02, 8'h11, 16'h0140, 16'h00F0, 32'h0102_0304, 8'h21, 8'h22, 8'h5A);
    exp1 = make_cfg(8'h02, 8'h11, 12'h140, 12'h0F0, 32'h0102_0304, 8'h21, 8'h22, 8'h5A);
    pulse_start();
    check("load1_busy", busy, 1'b1);
    send_img(0, 43, 0, t0, drops);
    check("load1_drops", drops, 0);
    wait_commit(exp1, t1);
    check("load1_latency", t1 - t0, 45);
    check("load1_cfg", config_out, exp1);
    check("load1_width", config_out.screen_width, 12'h140);
    check("load1_height", config_out.screen_height, 12'h0F0);
    check("load1_s0", config_out.input_s_config[0], 32'h0102_0304);
    check("load1_acl", config_out.input_acl_config, 8'h5A);
    check("load1_mpu", config_out.mpu, 8'h02);
    check("load1_error", error, 1'b0);
    check("load1_busy_done", busy, 1'b0);

    // Bad second magic byte.
    pulse_start();
    send_byte(8'h47, 0, took, t0);
    send_byte(8'h58, 0, took, t0);
    @(negedge clk);
    check("magic_in_ready", in_ready, 1'b0);
    check("magic_busy", busy, 1'b0);
    @(negedge clk);
    check("magic_error", error, 1'b1);
    check("magic_code", error_code, 2'd1);
    check("magic_keeps_valid", config_valid, 1'b1);
    check("magic_keeps_cfg", config_out, exp1);
    tick();
    send_byte(8'h47, 0, took, t0);
    check("magic_idle_no_accept", took, 1'b0);

    // Bad version, then a fresh valid image.
    pulse_start();
    check("ver_start_clears", error, 1'b0);
    send_byte(8'h47, 0, took, t0);
    send_byte(8'h57, 0, took, t0);
    send_byte(8'h02, 0, took, t0);
    @(negedge clk);
    @(negedge clk);
    check("ver_error", error, 1'b1);
    check("ver_code", error_code, 2'd2);
    tick();
    pulse_start();
    check("ver_restart_err", error, 1'b0);
    check("ver_restart_code", error_code, 2'd0);
    fill_img(8'h03, 8'h44, 16'h0FFF, 16'h0001, 32'hDEAD_BEEF, 8'h31, 8'h32, 8'hA5);
    exp2 = make_cfg(8'h03, 8'h44, 12'hFFF, 12'h001, 32'hDEAD_BEEF, 8'h31, 8'h32, 8'hA5);
    send_img(0, 43, 0, t0, drops);
    check("load2_drops", drops, 0);
    wait_commit(exp2, t1);
    check("load2_seen", t1 - t0, 45);
    check("load2_cfg", config_out, exp2);
    check("load2_s7", config_out.input_s_config[7], 32'hDEAD_BEF6);

    // Width upper nibble set.
    tick();
    pulse_start();
    send_byte(8'h47, 0, took, t0);
    send_byte(8'h57, 0, took, t0);
    send_byte(8'h01, 0, took, t0);
    send_byte(8'h03, 0, took, t0);
    send_byte(8'h44, 0, took, t0);
    send_byte(8'h11, 0, took, t0);
    @(negedge clk);
    @(negedge clk);
    check("width_error", error, 1'b1);
    check("width_code", error_code, 2'd3);
    check("width_no_commit", config_out, exp2);
    check("width_valid", config_valid, 1'b1);

    // Stall after byte 10: FAIL after 16 idle cycles.
    tick();
    pulse_start();
    send_img(0, 10, 0, t0, drops);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
    end
    check("tmo_idle_cycles", n, 16);
    @(negedge clk);
    check("tmo_error", error, 1'b1);
    check("tmo_code", error_code, 2'd3);
    check("tmo_busy", busy, 1'b0);
    check("tmo_keeps_cfg", config_out, exp2);

    // Abort at byte 20 with start, then a full image with random gaps.
    tick();
    fill_img(8'h77, 8'h66, 16'h0055, 16'h0066, 32'h5555_0000, 8'h01, 8'h02, 8'h03);
    pulse_start();
    send_img(0, 19, 3, t0, drops);
    in_valid = 1'b1;
    in_data  = img[20];
    start    = 1'b1;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1'b0);
    check("abort_keeps_cfg", config_out, exp2);
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check("abort_busy", busy, 1'b1);
    fill_img(8'h04, 8'h99, 16'h0280, 16'h01E0, 32'hCAFE_0100, 8'h41, 8'h42, 8'h43);
    exp3 = make_cfg(8'h04, 8'h99, 12'h280, 12'h1E0, 32'hCAFE_0100, 8'h41, 8'h42, 8'h43);
    send_img(0, 43, 3, t0, drops);
    check("load3_drops", drops, 0);
    wait_commit(exp3, t1);
    check("load3_committed", t1 > 0, 1'b1);
    check("load3_cfg", config_out, exp3);
    check("load3_error", error, 1'b0);

    // Asynchronous reset in the middle of a load.
    tick();
    pulse_start();
    send_img(0, 9, 0, t0, drops);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_config_valid", config_valid, 1'b0);
    check("arst_config_out", config_out, '0);
    check("arst_busy", busy, 1'b0);
    check("arst_in_ready", in_ready, 1'b0);
    check("arst_error", error, 1'b0);
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_valid", config_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
